// File: rtl/wb_dual_stage.sv
// wb_dual_stage: dual-lane MEM/WB pipeline register and writeback formatter.
// Captures both M-stage lanes, formats load data and drives the two
// register-file write ports. Lane 2 is the younger instruction, so it wins
// when both lanes target the same register. Keeps a retired-lane counter.
module wb_dual_stage (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Flush,
  // lane 1
  input  logic        M_Valid1,
  input  logic        M_RegWrite1,
  input  logic        M_MemToReg1,
  input  logic [4:0]  M_WR1,
  input  logic [31:0] M_ALU1,
  input  logic [31:0] M_LoadData1,
  input  logic [1:0]  M_LdSize1,
  input  logic        M_LdSigned1,
  input  logic [1:0]  M_AddrLo1,
  // lane 2
  input  logic        M_Valid2,
  input  logic        M_RegWrite2,
  input  logic        M_MemToReg2,
  input  logic [4:0]  M_WR2,
  input  logic [31:0] M_ALU2,
  input  logic [31:0] M_LoadData2,
  input  logic [1:0]  M_LdSize2,
  input  logic        M_LdSigned2,
  input  logic [1:0]  M_AddrLo2,
  // register-file write ports
  output logic        Write,
  output logic        Write2,
  output logic [4:0]  WR,
  output logic [4:0]  WR2,
  output logic [31:0] WD,
  output logic [31:0] WD2,
  output logic [31:0] Retired
);

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memtoreg;
    logic [4:0]  wr;
    logic [31:0] alu;
    logic [31:0] loaddata;
    logic [1:0]  ldsize;
    logic        ldsigned;
    logic [1:0]  addrlo;
  } lane_t;

  lane_t m_lane1, m_lane2;
  lane_t w_lane1, w_lane2;

  assign m_lane1 = '{valid: M_Valid1, regwrite: M_RegWrite1, memtoreg: M_MemToReg1,
                     wr: M_WR1, alu: M_ALU1, loaddata: M_LoadData1,
                     ldsize: M_LdSize1, ldsigned: M_LdSigned1, addrlo: M_AddrLo1};
  assign m_lane2 = '{valid: M_Valid2, regwrite: M_RegWrite2, memtoreg: M_MemToReg2,
                     wr: M_WR2, alu: M_ALU2, loaddata: M_LoadData2,
                     ldsize: M_LdSize2, ldsigned: M_LdSigned2, addrlo: M_AddrLo2};

  // Little-endian load extraction and sign/zero extension.
  // Half-word selection ignores addrlo[0]; size 11 behaves as a word.
  function automatic logic [31:0] format_load(input lane_t l);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = l.loaddata[{l.addrlo, 3'b000} +: 8];
    h = l.addrlo[1] ? l.loaddata[31:16] : l.loaddata[15:0];
    case (l.ldsize)
      2'b01:   r = {{16{l.ldsigned & h[15]}}, h};
      2'b10:   r = {{24{l.ldsigned & b[7]}}, b};
      default: r = l.loaddata;
    endcase
    return r;
  endfunction

  // W register: reset clears, flush kills both lanes (even while stalled),
  // stall holds, otherwise capture the M stage.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      w_lane1 <= '0;
      w_lane2 <= '0;
    end else if (Flush) begin
      w_lane1.valid <= 1'b0;
      w_lane2.valid <= 1'b0;
    end else if (!Stall) begin
      w_lane1 <= m_lane1;
      w_lane2 <= m_lane2;
    end
  end

  // Retired counter: lanes leaving W commit on any unstalled edge,
  // including a flush edge; writes to $0 still count.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Retired <= '0;
    end else if (!Stall) begin
      Retired <= Retired + 32'(w_lane1.valid) + 32'(w_lane2.valid);
    end
  end

  // Write-port drive: lane 2 suppresses a same-register write from lane 1.
  assign Write2 = w_lane2.valid & w_lane2.regwrite & (w_lane2.wr != 5'd0) & ~Stall;
  assign Write  = w_lane1.valid & w_lane1.regwrite & (w_lane1.wr != 5'd0) & ~Stall
                & ~(Write2 & (w_lane1.wr == w_lane2.wr));

  assign WR  = w_lane1.wr;
  assign WR2 = w_lane2.wr;
  assign WD  = w_lane1.memtoreg ? format_load(w_lane1) : w_lane1.alu;
  assign WD2 = w_lane2.memtoreg ? format_load(w_lane2) : w_lane2.alu;

endmodule

// File: tb/tb_wb_dual_stage.sv
// Directed testbench for wb_dual_stage with a scoreboard of expected
// write-port contents and a reference model of the retired counter.
module tb_wb_dual_stage;

  typedef struct packed {
    logic        valid;
    logic        rw;
    logic        m2r;
    logic [4:0]  wr;
    logic [31:0] alu;
    logic [31:0] ld;
    logic [1:0]  size;
    logic        sgn;
    logic [1:0]  addr;
  } lane_t;

  typedef struct {
    logic        we1;
    logic [4:0]  wr1;
    logic [31:0] wd1;
    logic        we2;
    logic [4:0]  wr2;
    logic [31:0] wd2;
    bit          chk_data;
  } exp_t;

  logic Clk, Reset, Stall, Flush;
  lane_t l1, l2;
  logic        Write, Write2;
  logic [4:0]  WR, WR2;
  logic [31:0] WD, WD2, Retired;

  int tests = 0;
  int fails = 0;
  exp_t sb[$];
  exp_t cur;
  logic [31:0] exp_ret;
  int w_cnt;

  wb_dual_stage dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
    .M_Valid1(l1.valid), .M_RegWrite1(l1.rw), .M_MemToReg1(l1.m2r), .M_WR1(l1.wr),
    .M_ALU1(l1.alu), .M_LoadData1(l1.ld), .M_LdSize1(l1.size), .M_LdSigned1(l1.sgn),
    .M_AddrLo1(l1.addr),
    .M_Valid2(l2.valid), .M_RegWrite2(l2.rw), .M_MemToReg2(l2.m2r), .M_WR2(l2.wr),
    .M_ALU2(l2.alu), .M_LoadData2(l2.ld), .M_LdSize2(l2.size), .M_LdSigned2(l2.sgn),
    .M_AddrLo2(l2.addr),
    .Write(Write), .Write2(Write2), .WR(WR), .WR2(WR2), .WD(WD), .WD2(WD2),
    .Retired(Retired)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference load formatter written with shifts and masks.
  function automatic logic [31:0] ref_fmt(input lane_t l);
    logic [31:0] s;
    if (l.size == 2'b10) begin
      s = (l.ld >> (8 * l.addr)) & 32'hFF;
      if (l.sgn && s[7]) s = s | 32'hFFFFFF00;
    end else if (l.size == 2'b01) begin
      s = (l.ld >> (l.addr[1] ? 16 : 0)) & 32'hFFFF;
      if (l.sgn && s[15]) s = s | 32'hFFFF0000;
    end else begin
      s = l.ld;
    end
    return s;
  endfunction

  function automatic exp_t model(input lane_t a, input lane_t b);
    exp_t e;
    e.we2 = b.valid && b.rw && (b.wr != 0);
    e.we1 = a.valid && a.rw && (a.wr != 0) && !(e.we2 && a.wr == b.wr);
    e.wr1 = a.wr;
    e.wr2 = b.wr;
    e.wd1 = a.m2r ? ref_fmt(a) : a.alu;
    e.wd2 = b.m2r ? ref_fmt(b) : b.alu;
    e.chk_data = 1'b1;
    return e;
  endfunction

  function automatic exp_t zero_exp(input bit chk);
    exp_t e;
    e = '{we1: 1'b0, wr1: 5'd0, wd1: 32'd0, we2: 1'b0, wr2: 5'd0, wd2: 32'd0, chk_data: chk};
    return e;
  endfunction

  // One clock edge: predict W and Retired from the currently driven inputs,
  // push the prediction, then pop it once the DUT has updated.
  task automatic tick();
    bit hold;
    exp_t nxt;
    hold = 1'b0;
    nxt = cur;
    if (Reset) begin
      exp_ret = 32'd0;
      w_cnt = 0;
      nxt = zero_exp(1'b1);
    end else begin
      if (!Stall) exp_ret = exp_ret + 32'(w_cnt);
      if (Flush) begin
        nxt = zero_exp(1'b0);
        w_cnt = 0;
      end else if (!Stall) begin
        nxt = model(l1, l2);
        w_cnt = int'(l1.valid) + int'(l2.valid);
      end else begin
        hold = 1'b1;
      end
    end
    if (!hold) sb.push_back(nxt);
    @(posedge Clk);
    #1;
    if (!hold) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL scoreboard: observed empty queue expected entry");
      end else begin
        cur = sb.pop_front();
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/Write"},  32'(Write),  32'(cur.we1 & !Stall));
    check({tag, "/Write2"}, 32'(Write2), 32'(cur.we2 & !Stall));
    if (cur.chk_data) begin
      check({tag, "/WR"},  32'(WR),  32'(cur.wr1));
      check({tag, "/WR2"}, 32'(WR2), 32'(cur.wr2));
      check({tag, "/WD"},  WD,  cur.wd1);
      check({tag, "/WD2"}, WD2, cur.wd2);
    end
    check({tag, "/Retired"}, Retired, exp_ret);
  endtask

  function automatic lane_t alu_lane(input logic [4:0] wr, input logic [31:0] v);
    lane_t l;
    l = '{valid: 1'b1, rw: 1'b1, m2r: 1'b0, wr: wr, alu: v, ld: 32'hDEAD0000,
          size: 2'b00, sgn: 1'b0, addr: 2'b00};
    return l;
  endfunction

  function automatic lane_t ld_lane(input logic [4:0] wr, input logic [31:0] d,
                                    input logic [1:0] size, input logic sgn,
                                    input logic [1:0] addr);
    lane_t l;
    l = '{valid: 1'b1, rw: 1'b1, m2r: 1'b1, wr: wr, alu: 32'hBAD0BAD0, ld: d,
          size: size, sgn: sgn, addr: addr};
    return l;
  endfunction

  initial begin
    cur = zero_exp(1'b1);
    exp_ret = 32'd0;
    w_cnt = 0;
    Stall = 1'b0;
    Flush = 1'b0;

    // Reset for two cycles with garbage M inputs.
    Reset = 1'b1;
    l1 = '{valid: 1'b1, rw: 1'b1, m2r: 1'b1, wr: 5'd17, alu: 32'hA5A5A5A5,
           ld: 32'h5A5A5A5A, size: 2'b10, sgn: 1'b1, addr: 2'b11};
    l2 = l1;
    l2.wr = 5'd18;
    tick();
    tick();
    check_all("reset");
    check("reset/WD_lit", WD, 32'd0);

    // Mixed lanes: ALU write plus signed byte load from the top byte.
    Reset = 1'b0;
    l1 = alu_lane(5'd5, 32'h12345678);
    l2 = ld_lane(5'd6, 32'h80FFFFFF, 2'b10, 1'b1, 2'd3);
    tick();
    check_all("mixed");
    check("mixed/WD2_lit", WD2, 32'hFFFFFF80);

    // Halfword loads, unsigned then signed, from the upper half.
    l1 = ld_lane(5'd8, 32'h80017FFF, 2'b01, 1'b0, 2'd2);
    l2 = ld_lane(5'd9, 32'h80017FFF, 2'b01, 1'b1, 2'd2);
    tick();
    check_all("half");
    check("half/WD_lit", WD, 32'h00008001);
    check("half/WD2_lit", WD2, 32'hFFFF8001);
    check("half/Retired_lit", Retired, 32'd2);

    // Unsigned byte at offset 1, lower half with AddrLo[0] set, size 11 word.
    l1 = ld_lane(5'd10, 32'h1234C681, 2'b10, 1'b0, 2'd1);
    l2 = ld_lane(5'd11, 32'hCAFEF00D, 2'b11, 1'b1, 2'd2);
    tick();
    check_all("byte_word");
    check("byte_word/WD_lit", WD, 32'h000000C6);
    l1 = ld_lane(5'd12, 32'h0000F00D, 2'b01, 1'b1, 2'd1);
    l2 = ld_lane(5'd13, 32'h89ABCDEF, 2'b10, 1'b1, 2'd0);
    tick();
    check_all("half_lo");
    check("half_lo/WD_lit", WD, 32'hFFFFF00D);

    // WAW: lane 2 wins the same destination.
    l1 = alu_lane(5'd7, 32'h11111111);
    l2 = alu_lane(5'd7, 32'h22222222);
    tick();
    check_all("waw");
    check("waw/Write_lit", 32'(Write), 32'd0);
    check("waw/Write2_lit", 32'(Write2), 32'd1);

    // $0 write suppressed but counted.
    l1 = alu_lane(5'd0, 32'h33333333);
    l2 = alu_lane(5'd3, 32'h44444444);
    l2.valid = 1'b0;
    tick();
    check_all("r0");
    l1 = alu_lane(5'd20, 32'h55555555);
    l2 = alu_lane(5'd21, 32'h66666666);
    tick();
    check_all("r0_count");

    // Stall three cycles with a valid W and changing M inputs.
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      l1 = alu_lane(5'(24 + i), 32'h70000000 + 32'(i));
      l2 = alu_lane(5'(28 + i), 32'h78000000 + 32'(i));
      tick();
      check_all("stall");
    end
    Stall = 1'b0;
    #1;
    check_all("release");
    tick();
    check_all("after_release");

    // Flush with valid M inputs: W lanes still commit, flushed lanes do not.
    Flush = 1'b1;
    l1 = alu_lane(5'd14, 32'h0F0F0F0F);
    l2 = alu_lane(5'd15, 32'hF0F0F0F0);
    tick();
    check_all("flush");
    Flush = 1'b0;
    l1.valid = 1'b0;
    l2.valid = 1'b0;
    tick();
    check_all("post_flush");

    // Reset while stalled with a valid W.
    l1 = alu_lane(5'd16, 32'h01020304);
    l2 = alu_lane(5'd17, 32'h05060708);
    tick();
    Stall = 1'b1;
    Reset = 1'b1;
    tick();
    Stall = 1'b0;
    Reset = 1'b0;
    #1;
    check_all("reset_in_stall");
    check("reset_in_stall/Retired_lit", Retired, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
